i2c_target_responder: RTL and testbench

- Synthesizable I2C target (slave) that answers transactions issued by the i2cmb master across the open-drain SCL/SDA bus.
- Decodes START, STOP and repeated START, and matches a 7-bit address.
- Delivers written bytes to a local write port and fetches read bytes through a request/acknowledge handshake.
- Serves as the bus-side counterpart of the master in system-level and emulation benches.

---
 rtl/i2c_target_responder.sv | 269 ++++++++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_responder.sv
// I2C target: START/STOP decode, 7-bit address match, write sink port and read fetch handshake.
// Define I2C_TARGET_CLK_STRETCH_EN to hold SCL low for late read data instead of sending 0xFF.
module i2c_target_responder #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h22,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe_o,
    output logic       sda_oe_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       busy_o,
    output logic       dir_o,
    output logic       wr_valid_o,
    output logic [7:0] wr_data_o,
    input  logic       wr_full_i,
    output logic       rd_req_o,
    input  logic       rd_ack_i,
    input  logic [7:0] rd_data_i,
    output logic       rd_underrun_o
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_FETCH, RD_BYTE, RD_ACK, WAIT_STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s, sda_s, scl_q, sda_q;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   hold_act, hold_fire, drive_fire, rel_load, stretching;
    logic [3:0]             bit_cnt;
    logic [6:0]             shreg;
    logic [7:0]             tx_byte;
    logic                   ack_ok;

`ifdef I2C_TARGET_CLK_STRETCH_EN
    logic rel_pend;
    assign rd_underrun_o = 1'b0;
    assign stretching    = scl_oe_o;
    assign drive_fire    = hold_fire & ~rel_pend;
    assign rel_load      = (state == RD_FETCH) && scl_oe_o && rd_req_o && rd_ack_i;
`else
    assign scl_oe_o      = 1'b0;
    assign stretching    = 1'b0;
    assign drive_fire    = hold_fire;
    assign rel_load      = 1'b0;
`endif

    // Input synchronizers plus one extra stage for edge detection; idle bus is high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    // Hold timer: fires HOLD_CYCLES after an SCL fall (or after late read data while stretching).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_cnt <= '0;
            hold_act <= 1'b0;
        end else if (scl_fall || rel_load) begin
            hold_cnt <= HOLD_W'(HOLD_CYCLES);
            hold_act <= 1'b1;
        end else if (hold_act) begin
            if (hold_cnt == HOLD_W'(1)) begin
                hold_act <= 1'b0;
            end else begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end

    assign hold_fire = hold_act && (hold_cnt == HOLD_W'(1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            tx_byte    <= '0;
            ack_ok     <= 1'b0;
            sda_oe_o   <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            busy_o     <= 1'b0;
            dir_o      <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_data_o  <= '0;
            rd_req_o   <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
            scl_oe_o   <= 1'b0;
            rel_pend   <= 1'b0;
`else
            rd_underrun_o <= 1'b0;
`endif
        end else begin
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            wr_valid_o <= 1'b0;
`ifndef I2C_TARGET_CLK_STRETCH_EN
            rd_underrun_o <= 1'b0;
`endif
            if (stop_det) begin
                stop_o   <= 1'b1;
                state    <= IDLE;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
                rd_req_o <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                scl_oe_o <= 1'b0;
                rel_pend <= 1'b0;
`endif
            end else if (start_det) begin
                start_o  <= 1'b1;
                state    <= ADDR;
                bit_cnt  <= '0;
                sda_oe_o <= 1'b0;
                rd_req_o <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                scl_oe_o <= 1'b0;
                rel_pend <= 1'b0;
`endif
            end else begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
                if (rel_pend && hold_fire) begin
                    scl_oe_o <= 1'b0;
                    rel_pend <= 1'b0;
                end
`endif
                case (state)
                    ADDR: begin
                        if (drive_fire) sda_oe_o <= 1'b0;
                        if (scl_rise) begin
                            shreg   <= {shreg[5:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (shreg == SLAVE_ADDR) begin
                                    dir_o  <= sda_s;
                                    busy_o <= 1'b1;
                                    state  <= ADDR_ACK;
                                end else begin
                                    busy_o <= 1'b0;
                                    state  <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (drive_fire) sda_oe_o <= 1'b1;
                        if (scl_rise) bit_cnt <= 4'd9;
                        if (scl_fall && bit_cnt == 4'd9) begin
                            bit_cnt <= '0;
                            if (dir_o) begin
                                state    <= RD_FETCH;
                                rd_req_o <= 1'b1;
                            end else begin
                                state    <= WR_BYTE;
                            end
                        end
                    end
                    WR_BYTE: begin
                        if (drive_fire) sda_oe_o <= 1'b0;
                        if (scl_rise) begin
                            shreg   <= {shreg[5:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                wr_data_o <= {shreg, sda_s};
                                state     <= WR_ACK;
                            end
                        end
                    end
                    // wr_full_i is only looked at on the falling edge that ends the data byte.
                    WR_ACK: begin
                        if (drive_fire) sda_oe_o <= ack_ok;
                        if (scl_rise) bit_cnt <= 4'd9;
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                ack_ok     <= ~wr_full_i;
                                wr_valid_o <= ~wr_full_i;
                            end else if (bit_cnt == 4'd9) begin
                                bit_cnt <= '0;
                                state   <= ack_ok ? WR_BYTE : WAIT_STOP;
                            end
                        end
                    end
                    // Data arriving at (or after) the drive point puts bit 7 on the bus immediately.
                    RD_FETCH: begin
                        if (rd_req_o && rd_ack_i) begin
                            rd_req_o <= 1'b0;
                            state    <= RD_BYTE;
                            if (drive_fire || stretching) begin
                                sda_oe_o <= ~rd_data_i[7];
                                tx_byte  <= {rd_data_i[6:0], 1'b0};
                                bit_cnt  <= 4'd1;
                            end else begin
                                tx_byte  <= rd_data_i;
                                bit_cnt  <= '0;
                            end
`ifdef I2C_TARGET_CLK_STRETCH_EN
                            if (scl_oe_o) rel_pend <= 1'b1;
`endif
                        end else if (drive_fire) begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
                            scl_oe_o <= 1'b1;
`else
                            sda_oe_o      <= 1'b0;
                            tx_byte       <= 8'hFE;
                            bit_cnt       <= 4'd1;
                            rd_req_o      <= 1'b0;
                            rd_underrun_o <= 1'b1;
                            state         <= RD_BYTE;
`endif
                        end
                    end
                    RD_BYTE: begin
                        if (drive_fire) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe_o <= 1'b0;
                                state    <= RD_ACK;
                            end else begin
                                sda_oe_o <= ~tx_byte[7];
                                tx_byte  <= {tx_byte[6:0], 1'b0};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                state    <= WAIT_STOP;
                            end else begin
                                state    <= RD_FETCH;
                                rd_req_o <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (drive_fire) sda_oe_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bus-level master model, read-data responder and scoreboards.
`timescale 1ns/1ps
module tb_i2c_target_responder;

    localparam int Q = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       scl_bus, sda_bus;
    logic       scl_oe, sda_oe, start_p, stop_p, busy, dir, wr_valid, rd_req, rd_underrun;
    logic [7:0] wr_data;
    logic       wr_full = 1'b0;
    logic       rd_ack = 1'b0;
    logic [7:0] rd_data = 8'h00;

    int n_checks = 0;
    int n_errors = 0;
    int n_start = 0, n_stop = 0, n_wr = 0, n_req = 0, n_underrun = 0;
    int n_sda_oe = 0, n_scl_oe = 0, n_busy = 0;
    int ack_delay = 2;
    logic req_prev = 1'b0;

    logic [7:0] rd_src_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] wr_exp_q[$];

    assign scl_bus = m_scl & ~scl_oe;
    assign sda_bus = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_responder dut (
        .clk_i(clk), .rst_n_i(rst_n), .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_oe_o(scl_oe), .sda_oe_o(sda_oe), .start_o(start_p), .stop_o(stop_p),
        .busy_o(busy), .dir_o(dir), .wr_valid_o(wr_valid), .wr_data_o(wr_data),
        .wr_full_i(wr_full), .rd_req_o(rd_req), .rd_ack_i(rd_ack), .rd_data_i(rd_data),
        .rd_underrun_o(rd_underrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Event counters and write scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (start_p) n_start++;
            if (stop_p) n_stop++;
            if (rd_underrun) n_underrun++;
            if (sda_oe) n_sda_oe++;
            if (scl_oe) n_scl_oe++;
            if (busy) n_busy++;
            if (rd_req && !req_prev) n_req++;
            req_prev = rd_req;
            if (wr_valid) begin
                n_wr++;
                if (wr_exp_q.size() == 0) check("wr_unexpected", 32'(wr_data), 32'hFFFF_FFFF);
                else check("wr_data", 32'(wr_data), 32'(wr_exp_q.pop_front()));
            end
        end else begin
            req_prev = 1'b0;
        end
    end

    // Local read-data source: answers rd_req after ack_delay cycles if it is still pending.
    initial begin
        int n;
        forever begin
            @(negedge clk);
            if (rst_n && rd_req) begin
                repeat (ack_delay) @(negedge clk);
                if (rst_n && rd_req) begin
                    rd_data = (rd_src_q.size() > 0) ? rd_src_q.pop_front() : 8'h00;
                    rd_ack = 1'b1;
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (rd_req && n < 100);
                    if (n >= 100) check("rd_req_stuck", 32'(rd_req), 32'h0);
                    rd_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_scl_high();
        int n = 0;
        while (!scl_bus && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("scl_release_timeout", 32'(scl_bus), 32'h1);
    endtask

    task automatic m_start();
        m_sda = 1'b0; wait_clks(Q);
        m_scl = 1'b0; wait_clks(Q);
    endtask

    task automatic m_rstart();
        m_sda = 1'b1; wait_clks(Q);
        m_scl = 1'b1; wait_scl_high(); wait_clks(Q);
        m_sda = 1'b0; wait_clks(Q);
        m_scl = 1'b0; wait_clks(Q);
    endtask

    task automatic m_stop();
        m_sda = 1'b0; wait_clks(Q);
        m_scl = 1'b1; wait_scl_high(); wait_clks(Q);
        m_sda = 1'b1; wait_clks(Q);
    endtask

    task automatic m_bit_write(input logic b);
        m_sda = b; wait_clks(Q);
        m_scl = 1'b1; wait_scl_high(); wait_clks(Q);
        m_scl = 1'b0; wait_clks(Q);
    endtask

    task automatic m_bit_read(output logic b);
        m_sda = 1'b1; wait_clks(Q);
        m_scl = 1'b1; wait_scl_high(); wait_clks(Q);
        b = sda_bus;
        m_scl = 1'b0; wait_clks(Q);
    endtask

    task automatic m_write_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) m_bit_write(v[i]);
        m_bit_read(ack);
    endtask

    task automatic m_read_byte(input string tag, input logic nack);
        logic [7:0] v;
        logic       b;
        for (int i = 0; i < 8; i++) begin
            m_bit_read(b);
            v = {v[6:0], b};
        end
        m_bit_write(nack);
        if (rd_exp_q.size() == 0) check({tag, "_noexp"}, 32'(v), 32'hFFFF_FFFF);
        else check(tag, 32'(v), 32'(rd_exp_q.pop_front()));
    endtask

    initial begin
        logic a;
        logic b;
        int s_start, s_stop, s_wr, s_req, s_und, s_sda, s_scl, s_busy;

        // Reset state
        wait_clks(3);
        check("reset_outputs", 32'({scl_oe, sda_oe, start_p, stop_p, busy, dir, wr_valid,
                                    wr_data, rd_req, rd_underrun}), 32'h0);
        rst_n = 1'b1;
        wait_clks(10);
        check("post_reset_busy", 32'(busy), 32'h0);

        // Plain write of two bytes
        s_start = n_start; s_stop = n_stop; s_wr = n_wr;
        wr_exp_q.push_back(8'hA5);
        wr_exp_q.push_back(8'h3C);
        m_start();
        m_write_byte(8'h44, a);  check("wr_addr_ack", 32'(a), 32'h0);
        check("wr_busy", 32'(busy), 32'h1);
        check("wr_dir", 32'(dir), 32'h0);
        m_write_byte(8'hA5, a);  check("wr_b1_ack", 32'(a), 32'h0);
        m_write_byte(8'h3C, a);  check("wr_b2_ack", 32'(a), 32'h0);
        m_stop();
        wait_clks(5);
        check("wr_busy_after_stop", 32'(busy), 32'h0);
        check("wr_stop_count", 32'(n_stop - s_stop), 32'h1);
        check("wr_start_count", 32'(n_start - s_start), 32'h1);
        check("wr_valid_count", 32'(n_wr - s_wr), 32'h2);

        // Address mismatch: never drive SDA, never go busy
        s_wr = n_wr; s_sda = n_sda_oe; s_busy = n_busy; s_stop = n_stop;
        m_start();
        m_write_byte(8'h46, a);  check("nm_addr_nack", 32'(a), 32'h1);
        m_write_byte(8'hAA, a);  check("nm_data_nack", 32'(a), 32'h1);
        m_stop();
        wait_clks(5);
        check("nm_sda_driven", 32'(n_sda_oe - s_sda), 32'h0);
        check("nm_busy_cycles", 32'(n_busy - s_busy), 32'h0);
        check("nm_wr_count", 32'(n_wr - s_wr), 32'h0);
        check("nm_stop_count", 32'(n_stop - s_stop), 32'h1);

        // Two-byte read, master ACKs then NACKs
        s_req = n_req; s_und = n_underrun;
        ack_delay = 2;
        rd_src_q.push_back(8'h81); rd_exp_q.push_back(8'h81);
        rd_src_q.push_back(8'h7E); rd_exp_q.push_back(8'h7E);
        m_start();
        m_write_byte(8'h45, a);  check("rd_addr_ack", 32'(a), 32'h0);
        check("rd_dir", 32'(dir), 32'h1);
        m_read_byte("rd_b1", 1'b0);
        m_read_byte("rd_b2", 1'b1);
        check("rd_released_after_nack", 32'({sda_oe, rd_req}), 32'h0);
        m_stop();
        wait_clks(5);
        check("rd_req_count", 32'(n_req - s_req), 32'h2);
        check("rd_underrun_none", 32'(n_underrun - s_und), 32'h0);

        // Sink full on second byte
        s_wr = n_wr;
        wr_exp_q.push_back(8'h11);
        m_start();
        m_write_byte(8'h44, a);  check("full_addr_ack", 32'(a), 32'h0);
        m_write_byte(8'h11, a);  check("full_b1_ack", 32'(a), 32'h0);
        wr_full = 1'b1;
        m_write_byte(8'h22, a);  check("full_b2_nack", 32'(a), 32'h1);
        wr_full = 1'b0;
        m_write_byte(8'h33, a);  check("full_b3_ignored", 32'(a), 32'h1);
        m_stop();
        wait_clks(5);
        check("full_wr_count", 32'(n_wr - s_wr), 32'h1);

        // Repeated START turns a write into a read
        s_start = n_start;
        wr_exp_q.push_back(8'h10);
        rd_src_q.push_back(8'h5A); rd_exp_q.push_back(8'h5A);
        m_start();
        m_write_byte(8'h44, a);  check("sr_waddr_ack", 32'(a), 32'h0);
        check("sr_dir_w", 32'(dir), 32'h0);
        m_write_byte(8'h10, a);  check("sr_wbyte_ack", 32'(a), 32'h0);
        m_rstart();
        m_write_byte(8'h45, a);  check("sr_raddr_ack", 32'(a), 32'h0);
        check("sr_dir_r", 32'(dir), 32'h1);
        m_read_byte("sr_rbyte", 1'b1);
        m_stop();
        wait_clks(5);
        check("sr_start_count", 32'(n_start - s_start), 32'h2);
        check("sr_wr_queue_empty", 32'(wr_exp_q.size()), 32'h0);

        // Read data withheld for 200 cycles
        s_und = n_underrun; s_scl = n_scl_oe;
        ack_delay = 200;
        rd_src_q.delete();
        rd_src_q.push_back(8'h55);
`ifdef I2C_TARGET_CLK_STRETCH_EN
        rd_exp_q.push_back(8'h55);
`else
        rd_exp_q.push_back(8'hFF);
`endif
        m_start();
        m_write_byte(8'h45, a);  check("late_addr_ack", 32'(a), 32'h0);
        m_read_byte("late_byte", 1'b1);
        m_stop();
        wait_clks(250);
`ifdef I2C_TARGET_CLK_STRETCH_EN
        check("late_scl_stretched", 32'(n_scl_oe - s_scl > 100), 32'h1);
        check("late_underrun", 32'(n_underrun - s_und), 32'h0);
`else
        check("late_scl_never_held", 32'(n_scl_oe - s_scl), 32'h0);
        check("late_underrun", 32'(n_underrun - s_und), 32'h1);
`endif
        check("late_scl_free", 32'(scl_oe), 32'h0);

        // Reset asserted in the middle of a read byte
        ack_delay = 2;
        rd_src_q.delete();
        rd_src_q.push_back(8'h00);
        m_start();
        m_write_byte(8'h45, a);  check("mid_addr_ack", 32'(a), 32'h0);
        for (int i = 0; i < 3; i++) m_bit_read(b);
        check("mid_sda_driven", 32'(sda_oe), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_oe", 32'({scl_oe, sda_oe}), 32'h0);
        check("mid_rst_outputs", 32'({start_p, stop_p, busy, dir, wr_valid, wr_data,
                                      rd_req, rd_underrun}), 32'h0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(10);
        check("mid_idle_after_reset", 32'({busy, sda_oe}), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
